alu_in_scheduler: RTL
=====================

# alu_in_scheduler

Round-robin scheduler that shares one ALU input port among `NUM_REQ` requesters. It sits between the requesters and the ALU's `alu_in` signal group. It accepts one operation at a time, drives the ALU valid/ready handshake, waits for completion under a timeout counter, and returns the result to the requester that was granted. It serialises all ALU access, so at most one operation is outstanding at any time.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `OP_WIDTH`, 8: operand width W.
- `TIMEOUT`, 64: cycles allowed in WAIT before an error response; must be at least 2.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_op`  in  3*NUM_REQ  per-requester opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op.
- `req_a`, `req_b`  in  W*NUM_REQ  per-requester operands.
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `resp_valid`  out  NUM_REQ  one-hot response pulse.
- `resp_result`  out  2W  result, shared by all requesters.
- `resp_err`  out  1  timeout flag, qualified by `resp_valid`.
- `alu_valid`  out  1  operation valid to the ALU.
- `alu_op`  out  3  opcode to the ALU.
- `alu_a`, `alu_b`  out  W  operands to the ALU.
- `alu_ready`  in  1  ALU can accept.
- `alu_done`  in  1  ALU result valid, one-cycle pulse.
- `alu_result`  in  2W  ALU result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State machine has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, grant the first valid index at or above `ptr`, wrapping modulo NUM_REQ.
  - Assert `req_ready[g]` combinationally for that cycle.
  - Capture op, a and b into holding registers; store g.
  - Set `ptr` to (g+1) mod NUM_REQ.
  - Next state: RESP if op is no_op, otherwise ISSUE.
- **ISSUE**
  - `alu_valid`=1; `alu_op`/`alu_a`/`alu_b` come from the holding registers and stay stable until `alu_ready`=1 is sampled.
  - On that handshake: next state is RESP for rst_op, WAIT for all other ops.
- **WAIT**
  - Timer clears on entry and increments each cycle.
  - `alu_done`=1: capture `alu_result`, clear the error flag, go to RESP.
  - Timer reaches TIMEOUT-1 with no `alu_done`: set the error flag, set the result register to 0, go to RESP.
  - `alu_done` and the timeout in the same cycle: `alu_done` wins.
- **RESP**
  - `resp_valid[g]`=1 for exactly one cycle, then go to IDLE.
  - Result is 0 for no_op and rst_op; `resp_err`=0 for both.
- `alu_done` is ignored outside WAIT.
- Undefined opcodes (101, 110) are treated as no_op.
- `req_*` inputs are sampled only in IDLE. Requesters hold their requests until `req_ready`; an ungranted requester keeps waiting.
- **Reset:** asynchronous. Every output and register goes to 0, state goes to IDLE, `ptr`=0. Any operation in flight is dropped with no response. Outputs return to 0 immediately on `rst` going low.

## Timing
- Outputs `alu_*`, `resp_*`, `resp_result` and `busy` are registered or decoded from state only; none is combinational from `alu_ready`/`alu_done`.
- `req_ready` is the exception: it is combinational from `req_valid` and `ptr` in IDLE.
- Latency for an ALU op accepted in cycle T:
  - `alu_valid` is high in T+1.
  - If `alu_ready` is high in T+1, WAIT starts in T+2.
  - `alu_done` in T+k gives `resp_valid` in T+k+1.
- Latency for no_op: accept in T, `resp_valid` in T+1.
- Throughput: the next grant is possible in the cycle after RESP.
- Fairness: with all requesters continuously valid, each receives exactly one grant per NUM_REQ grants.

## Test plan
- **Reset:** with `rst` held low, every output is 0 and `busy`=0. On release with `req_valid`=0001, grant 0 in the first IDLE cycle.
- **Single add:** requester 2 sends op 001, a=8'h05, b=8'h03; ALU ready immediately, `alu_done` 3 cycles later with 16'h0008. Expect `alu_valid` at T+1 and `resp_valid`=0100 with result 16'h0008 and `resp_err`=0 at T+5.
- **Round-robin:** all four requesters valid for 8 grants. Expect grant order 0,1,2,3,0,1,2,3, no requester starved.
- **Backpressure:** `alu_ready` held low for 5 cycles. Expect `alu_valid` held with op/a/b unchanged, and exactly one handshake.
- **Timeout:** mul op with `alu_done` never asserted and TIMEOUT=64. Expect `resp_valid` 64 cycles after WAIT entry, `resp_err`=1, result 0, then return to IDLE.
- **Corner cases:**
  - no_op: response in 1 cycle, `alu_valid` never asserted.
  - rst_op: response right after the ALU handshake.
  - Async reset in WAIT: outputs clear immediately, no response; the next request is served normally.

Source files
------------

// File: rtl/alu_in_scheduler.sv
// alu_in_scheduler: round-robin arbiter serialising NUM_REQ requesters onto one ALU input port
module alu_in_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int OP_WIDTH = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [3*NUM_REQ-1:0]      req_op,
  input  logic [OP_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [OP_WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [2*OP_WIDTH-1:0]     resp_result,
  output logic                      resp_err,
  output logic                      alu_valid,
  output logic [2:0]                alu_op,
  output logic [OP_WIDTH-1:0]       alu_a,
  output logic [OP_WIDTH-1:0]       alu_b,
  input  logic                      alu_ready,
  input  logic                      alu_done,
  input  logic [2*OP_WIDTH-1:0]     alu_result,
  output logic                      busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, gnt, g_q;
  logic found, issue_op, timeout;
  int idx;
  logic [TW-1:0] timer;
  logic [2:0] op_q;
  logic [OP_WIDTH-1:0] a_q, b_q;
  logic [2*OP_WIDTH-1:0] res_q;
  logic err_q;
  logic [2:0] ops [NUM_REQ];
  logic [OP_WIDTH-1:0] opa [NUM_REQ];
  logic [OP_WIDTH-1:0] opb [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign ops[i] = req_op[3*i +: 3];
    assign opa[i] = req_a[OP_WIDTH*i +: OP_WIDTH];
    assign opb[i] = req_b[OP_WIDTH*i +: OP_WIDTH];
  end
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[IW'(idx)]) begin
        found = 1'b1;
        gnt = IW'(idx);
      end
    end
  end
  // undefined opcodes fall through to the no_op path
  assign issue_op = ops[gnt] inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
  assign timeout = timer == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = issue_op ? ISSUE : RESP;
      ISSUE:   if (alu_ready) state_nx = (op_q == 3'b111) ? RESP : WAIT;
      WAIT:    if (alu_done || timeout) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      g_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      timer <= '0;
    end else begin
      unique case (state)
        IDLE: if (found) begin
          g_q <= gnt;
          ptr <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
          op_q <= ops[gnt];
          a_q <= opa[gnt];
          b_q <= opb[gnt];
          res_q <= '0;
          err_q <= 1'b0;
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          if (alu_done) begin
            res_q <= alu_result;
            err_q <= 1'b0;
          end else if (timeout) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  // rst gates the combinational grant so every output reads 0 during reset
  assign req_ready = (rst && state == IDLE && found) ? NUM_REQ'(1) << gnt : '0;
  assign resp_valid = (state == RESP) ? NUM_REQ'(1) << g_q : '0;
  assign resp_result = res_q;
  assign resp_err = err_q;
  assign alu_valid = state == ISSUE;
  assign alu_op = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign busy = state != IDLE;
endmodule
